// File: rtl/paillier_encryptor.sv
// Paillier encryption c = (1 + m*n) * r^n mod n^2 with g = n+1.
// One sequential square-and-multiply exponentiation over the bits of n,
// where every modular multiply is a one-cycle product load followed by
// 4W cycles of restoring shift-subtract reduction against n^2.
//
// Handshake: start is sampled only while the FSM is in IDLE. The edge that
// samples it high is the accept edge: it latches n/m/r, raises busy and
// clears err. While busy is high, start is ignored and nothing is queued.
// done is a one-cycle pulse; c_out and err are valid with it. busy falls on
// the same edge that raises done. c_out holds until the next done, and err
// holds until the next accept.
module paillier_encryptor #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   n_in,
    input  logic [W-1:0]   m_in,
    input  logic [W-1:0]   r_in,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*W-1:0] c_out,
    output logic [2:0]     dbg_state_o
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(4 * W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(4 * W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_EXP_SQR = 3'd2,
        S_EXP_MUL = 3'd3,
        S_FINAL   = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   n_q, n_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   r_q, r_d;
    logic [2*W-1:0] n2_q, n2_d;
    logic [2*W-1:0] gm_q, gm_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4*W-1:0] p_q, p_d;
    logic [2*W-1:0] rem_q, rem_d;
    logic           err_pend_q, err_pend_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [2*W-1:0] c_q, c_d;

    // Multiplier operands, full-width product and one reduction step.
    logic [2*W-1:0] mul_a, mul_b;
    logic [4*W-1:0] prod;
    logic [2*W:0]   rem_shift;
    logic           rem_ge;
    logic [2*W-1:0] rem_sub;
    logic [2*W-1:0] mul_res;
    logic           mul_last;
    logic           in_mult;
    logic [2*W-1:0] nn_prod;
    logic [2*W-1:0] mn_prod;
    logic           op_illegal;

    // Shared multiply/reduce datapath; operand selection follows the state.
    always_comb begin
        mul_a   = acc_q;
        mul_b   = acc_q;
        in_mult = 1'b0;
        case (state_q)
            S_EXP_SQR: begin
                mul_a   = acc_q;
                mul_b   = acc_q;
                in_mult = 1'b1;
            end
            S_EXP_MUL: begin
                mul_a   = acc_q;
                mul_b   = {{W{1'b0}}, r_q};
                in_mult = 1'b1;
            end
            S_FINAL: begin
                mul_a   = gm_q;
                mul_b   = acc_q;
                in_mult = 1'b1;
            end
            default: begin
                mul_a   = acc_q;
                mul_b   = acc_q;
                in_mult = 1'b0;
            end
        endcase
        prod      = {{2*W{1'b0}}, mul_a} * {{2*W{1'b0}}, mul_b};
        // Remainder stays below n^2, so one conditional subtract suffices and
        // the difference always fits back into 2W bits.
        rem_shift = {rem_q, p_q[4*W-1]};
        rem_ge    = rem_shift >= {1'b0, n2_q};
        rem_sub   = rem_shift[2*W-1:0] - n2_q;
        mul_res   = rem_ge ? rem_sub : rem_shift[2*W-1:0];
        mul_last  = (cnt_q == CNT_LAST);
        nn_prod   = {{W{1'b0}}, n_q} * {{W{1'b0}}, n_q};
        mn_prod   = {{W{1'b0}}, m_q} * {{W{1'b0}}, n_q};
        op_illegal = (n_q < W'(2)) || (m_q >= n_q) || (r_q == '0) || (r_q >= n_q);
    end

    // Next-state and register updates for the FSM and working registers.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        m_d        = m_q;
        r_d        = r_q;
        n2_d       = n2_q;
        gm_d       = gm_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        rem_d      = rem_q;
        err_pend_d = err_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        c_d        = c_q;

        // Common multiply sequencing: load product, then shift-subtract.
        if (in_mult) begin
            if (cnt_q == '0) begin
                p_d   = prod;
                rem_d = '0;
                cnt_d = CW'(1);
            end else begin
                p_d   = {p_q[4*W-2:0], 1'b0};
                rem_d = mul_res;
                cnt_d = mul_last ? '0 : cnt_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_in;
                    m_d     = m_in;
                    r_d     = r_in;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                n2_d       = nn_prod;
                gm_d       = mn_prod + (2*W)'(1);
                acc_d      = (2*W)'(1);
                idx_d      = IW'(W - 1);
                cnt_d      = '0;
                err_pend_d = op_illegal;
                state_d    = op_illegal ? S_DONE : S_EXP_SQR;
            end
            S_EXP_SQR: begin
                if (cnt_q != '0 && mul_last) begin
                    acc_d   = mul_res;
                    state_d = S_EXP_MUL;
                end
            end
            S_EXP_MUL: begin
                // The multiply always runs; only the write-back depends on the bit.
                if (cnt_q != '0 && mul_last) begin
                    if (n_q[idx_q]) begin
                        acc_d = mul_res;
                    end
                    if (idx_q == '0) begin
                        state_d = S_FINAL;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = S_EXP_SQR;
                    end
                end
            end
            S_FINAL: begin
                if (cnt_q != '0 && mul_last) begin
                    acc_d   = mul_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                c_d     = err_pend_q ? '0 : acc_q;
                err_d   = err_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            m_q        <= '0;
            r_q        <= '0;
            n2_q       <= '0;
            gm_q       <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            p_q        <= '0;
            rem_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            c_q        <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            m_q        <= m_d;
            r_q        <= r_d;
            n2_q       <= n2_d;
            gm_q       <= gm_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            rem_q      <= rem_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            c_q        <= c_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign c_out       = c_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_paillier_encryptor.sv
// Directed bench for paillier_encryptor: a vector table with hand-computed
// ciphertexts and latencies, plus sequences for start-while-busy, mid-run
// reset and back-to-back operation with start held high.
module tb_paillier_encryptor;

    localparam int W = 8;
    localparam int LAT_OK  = 563;
    localparam int LAT_ERR = 2;
    localparam int MAX_WAIT = 1000;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   n_in, m_in, r_in;
    logic           busy, done, err;
    logic [2*W-1:0] c_out;
    logic [2:0]     dbg_state;

    int checks;
    int failures;

    typedef struct {
        logic [W-1:0]   n;
        logic [W-1:0]   m;
        logic [W-1:0]   r;
        logic [2*W-1:0] c;
        logic           e;
        int             lat;
    } vec_t;

    vec_t vecs[13];

    paillier_encryptor #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_in        (n_in),
        .m_in        (m_in),
        .r_in        (r_in),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .c_out       (c_out),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present operands and start away from the edge; the next posedge accepts.
    task automatic accept(input logic [W-1:0] n, input logic [W-1:0] m,
                          input logic [W-1:0] r, input bit hold);
        @(negedge clk);
        n_in  = n;
        m_in  = m;
        r_in  = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Count edges until done is seen; optionally note any drop of busy first.
    task automatic wait_done(input bit chk_busy, output int lat,
                             output bit timeout, output bit busy_bad);
        lat      = 0;
        timeout  = 1'b1;
        busy_bad = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (chk_busy && !busy) busy_bad = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit to, bb;
        logic [2*W-1:0] held;
        accept(v.n, v.m, v.r, 1'b0);
        chk($sformatf("v%0d busy_after_accept", idx), busy, 1);
        wait_done(1'b1, lat, to, bb);
        chk($sformatf("v%0d timeout", idx), to, 0);
        chk($sformatf("v%0d c_out", idx), c_out, v.c);
        chk($sformatf("v%0d err", idx), err, v.e);
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d busy_dropped_early", idx), bb, 0);
        chk($sformatf("v%0d busy_with_done", idx), busy, 0);
        held = c_out;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d done_one_cycle", idx), done, 0);
        chk($sformatf("v%0d c_out_held", idx), c_out, v.c);
        chk($sformatf("v%0d err_held", idx), err, v.e);
    endtask

    initial begin
        int lat, lat2;
        bit to, bb;
        int seen;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        n_in     = '0;
        m_in     = '0;
        r_in     = '0;

        //           n    m    r    c      e     lat
        vecs[0]  = '{8'd15,  8'd4,   8'd2,  16'd173,   1'b0, LAT_OK};
        vecs[1]  = '{8'd15,  8'd14,  8'd14, 16'd14,    1'b0, LAT_OK};
        vecs[2]  = '{8'd143, 8'd0,   8'd1,  16'd1,     1'b0, LAT_OK};
        vecs[3]  = '{8'd15,  8'd0,   8'd2,  16'd143,   1'b0, LAT_OK};
        vecs[4]  = '{8'd3,   8'd1,   8'd2,  16'd5,     1'b0, LAT_OK};
        vecs[5]  = '{8'd2,   8'd1,   8'd1,  16'd3,     1'b0, LAT_OK};
        vecs[6]  = '{8'd255, 8'd254, 8'd1,  16'd64771, 1'b0, LAT_OK};
        vecs[7]  = '{8'd5,   8'd2,   8'd3,  16'd23,    1'b0, LAT_OK};
        vecs[8]  = '{8'd1,   8'd0,   8'd0,  16'd0,     1'b1, LAT_ERR};
        vecs[9]  = '{8'd15,  8'd15,  8'd2,  16'd0,     1'b1, LAT_ERR};
        vecs[10] = '{8'd15,  8'd4,   8'd0,  16'd0,     1'b1, LAT_ERR};
        vecs[11] = '{8'd15,  8'd4,   8'd20, 16'd0,     1'b1, LAT_ERR};
        vecs[12] = '{8'd15,  8'd4,   8'd15, 16'd0,     1'b1, LAT_ERR};

        // Reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset c_out", c_out, 0);
        chk("reset state", dbg_state, 0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // start with new operands mid-operation is ignored
        accept(8'd15, 8'd4, 8'd2, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        n_in  = 8'd5;
        m_in  = 8'd2;
        r_in  = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b1, lat, to, bb);
        chk("midstart timeout", to, 0);
        chk("midstart latency", 101 + lat, LAT_OK);
        chk("midstart c_out", c_out, 173);
        chk("midstart busy_dropped_early", bb, 0);
        @(posedge clk);
        #1;
        chk("midstart no_second_run", busy, 0);

        // reset mid-operation abandons the run
        accept(8'd5, 8'd2, 8'd3, 1'b0);
        repeat (200) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset err", err, 0);
        chk("midreset c_out", c_out, 0);
        chk("midreset state", dbg_state, 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("midreset no_done", seen, 0);
        run_vec(vecs[0], 100);

        // start held high: back-to-back runs
        accept(8'd15, 8'd4, 8'd2, 1'b1);
        wait_done(1'b0, lat, to, bb);
        chk("b2b first timeout", to, 0);
        chk("b2b first latency", lat, LAT_OK);
        chk("b2b first c_out", c_out, 173);
        wait_done(1'b0, lat2, to, bb);
        start = 1'b0;
        chk("b2b second timeout", to, 0);
        chk("b2b done spacing", lat2, LAT_OK + 1);
        chk("b2b second c_out", c_out, 173);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b idle after release", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
